// File: rtl/spi_pkg.sv
// SPI master shared definitions:
// register map, field positions, FSM states.
package spi_pkg;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_CFG  = 3'd1;
  localparam logic [2:0] A_DIV  = 3'd2;
  localparam logic [2:0] A_TX   = 3'd3;
  localparam logic [2:0] A_RX   = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int CFG_CPHA   = 0;
  localparam int CFG_CPOL   = 1;
  localparam int CFG_LSB    = 2;
  localparam int CFG_LEN_LO = 8;
  localparam int CFG_LEN_HI = 12;
  localparam int CFG_CS_LO  = 16;
  localparam int CFG_CS_HI  = 18;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } spi_state_e;

  // Register position of the k-th bit on the wire.
  function automatic logic [4:0] bit_pos(
    input logic [5:0] len,
    input logic       lsb,
    input logic [5:0] k
  );
    logic [5:0] p;
    p = lsb ? k : (len - 6'd1 - k);
    return p[4:0];
  endfunction

  // k-th wire bit of a frame, 0 past the end.
  function automatic logic frame_bit(
    input logic [31:0] d,
    input logic [5:0]  len,
    input logic        lsb,
    input logic [5:0]  k
  );
    return (k < len) ? d[bit_pos(len, lsb, k)] : 1'b0;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI edge-tick generator: one-cycle tick
// every DIV+1 clocks while enabled.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Half-period counter, held at zero when idle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = en && (cnt == div);

endmodule

// File: rtl/spi_master_param.sv
// Register-mapped SPI master with
// configurable mode, length, order and CS.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int NUM_CS  = 4,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        addr,
  input  logic              we,
  input  logic [31:0]       write_data,
  input  logic              re,
  output logic [31:0]       read_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              irq
);

  localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);
  localparam logic [3:0] NCS     = 4'(NUM_CS);

  spi_state_e state, state_nxt;

  logic             irq_en;
  logic             cpha;
  logic             cpol;
  logic             lsb;
  logic [4:0]       len_raw;
  logic [2:0]       cs_raw;
  logic [DIV_W-1:0] div;
  logic [31:0]      tx;
  logic [31:0]      rx;
  logic [31:0]      rx_sh;
  logic             done;
  logic             start_pend;

  logic [5:0]       len;
  logic [2:0]       sel;
  logic             tick;
  logic [6:0]       edge_cnt;
  logic [5:0]       tx_idx;
  logic [5:0]       rx_idx;

  logic             start_wr;
  logic             go;
  logic             last_edge;
  logic             samp;
  logic             done_set;
  logic             done_clr;
  logic             nxt_act;
  logic [31:0]      rd_val;

  // Effective length and chip select after clamping.
  always_comb begin
    len = {1'b0, len_raw} + 6'd1;
    if (len > LEN_MAX) len = LEN_MAX;
    sel = ({1'b0, cs_raw} < NCS) ? cs_raw : 3'd0;
  end

  assign busy     = (state == LEAD) ||
                    (state == SHIFT) ||
                    (state == TRAIL);
  assign irq      = done && irq_en;
  assign start_wr = we && (addr == A_CTRL) &&
                    write_data[CTRL_START];
  assign go       = (state == IDLE) &&
                    (start_wr || start_pend);
  assign last_edge = edge_cnt == ({len, 1'b0} - 7'd1);
  assign samp     = cpha ? edge_cnt[0] : ~edge_cnt[0];
  assign done_set = (state == TRAIL) && tick;
  assign done_clr = (re && addr == A_RX) ||
                    (we && addr == A_STAT &&
                     write_data[STAT_DONE]);
  assign nxt_act  = (state_nxt == LEAD) ||
                    (state_nxt == SHIFT) ||
                    (state_nxt == TRAIL);

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .div (div),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame sequencing.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (go) state_nxt = LEAD;
      LEAD:  if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && last_edge) state_nxt = TRAIL;
      TRAIL: if (tick) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register writes; frame config frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en  <= 1'b0;
      cpha    <= 1'b0;
      cpol    <= 1'b0;
      lsb     <= 1'b0;
      len_raw <= '0;
      cs_raw  <= '0;
      div     <= '0;
      tx      <= '0;
    end else if (we) begin
      unique case (1'b1)
        (addr == A_CTRL): begin
          irq_en <= write_data[CTRL_IRQ_EN];
        end
        (addr == A_CFG && !busy): begin
          cpha    <= write_data[CFG_CPHA];
          cpol    <= write_data[CFG_CPOL];
          lsb     <= write_data[CFG_LSB];
          len_raw <= write_data[CFG_LEN_HI:CFG_LEN_LO];
          cs_raw  <= write_data[CFG_CS_HI:CFG_CS_LO];
        end
        (addr == A_DIV && !busy): begin
          div <= write_data[DIV_W-1:0];
        end
        (addr == A_TX && !busy): begin
          tx <= write_data;
        end
        default: ;
      endcase
    end
  end

  // Chip select follows the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n <= '1;
    end else if (nxt_act) begin
      cs_n <= ~(NUM_CS'(1) << sel);
    end else begin
      cs_n <= '1;
    end
  end

  // Shift datapath, sclk, done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi       <= 1'b0;
      sclk       <= 1'b0;
      tx_idx     <= '0;
      rx_idx     <= '0;
      edge_cnt   <= '0;
      rx_sh      <= '0;
      rx         <= '0;
      done       <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      if (state == DONE && start_wr) begin
        start_pend <= 1'b1;
      end else if (go) begin
        start_pend <= 1'b0;
      end

      if (state != SHIFT) begin
        sclk <= cpol;
      end else if (tick) begin
        sclk <= ~sclk;
      end

      if (go) begin
        edge_cnt <= '0;
        rx_idx   <= '0;
        rx_sh    <= '0;
        if (!cpha) begin
          mosi   <= frame_bit(tx, len, lsb, 6'd0);
          tx_idx <= 6'd1;
        end else begin
          tx_idx <= 6'd0;
        end
      end

      if (state == SHIFT && tick) begin
        edge_cnt <= edge_cnt + 7'd1;
        if (samp) begin
          rx_sh[bit_pos(len, lsb, rx_idx)] <= miso;
          rx_idx <= rx_idx + 6'd1;
        end else if (tx_idx < len) begin
          mosi   <= frame_bit(tx, len, lsb, tx_idx);
          tx_idx <= tx_idx + 6'd1;
        end
      end

      if (done_set) begin
        done <= 1'b1;
        rx   <= rx_sh;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

  // Read mux.
  always_comb begin
    rd_val = '0;
    case (addr)
      A_CTRL: rd_val = {30'b0, irq_en, 1'b0};
      A_CFG:  rd_val = {13'b0, cs_raw, 3'b0,
                        len_raw, 5'b0,
                        lsb, cpol, cpha};
      A_DIV:  rd_val = 32'(div);
      A_TX:   rd_val = tx;
      A_RX:   rd_val = rx;
      A_STAT: rd_val = {30'b0, done, busy};
      default: rd_val = '0;
    endcase
  end

  // Registered read port, holds between reads.
  always_ff @(posedge clk) begin
    if (rst)     read_data <= '0;
    else if (re) read_data <= rd_val;
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param:
// frame and register-read monitors.
module tb_spi_master_param;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [3:0]  cs_n;
  logic        busy;
  logic        irq;

  int miso_mode = 0;
  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1);

  spi_master_param dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .we        (we),
    .write_data(write_data),
    .re        (re),
    .read_data (read_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cpha;
    bit          cpol;
    bit          lsb;
    int          len;
    int          sel;
    int          cycles;
    logic [31:0] word;
  } frm_t;

  frm_t        frm_q[$];
  logic [31:0] rd_q[$];
  string       rdn_q[$];

  int n_pass = 0;
  int n_tot  = 0;
  bit abort_req = 1'b0;
  bit irq_en = 1'b0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endfunction

  function automatic logic [31:0] mask(int len);
    return 32'((64'd1 << len) - 64'd1);
  endfunction

  function automatic logic [31:0] exp_rx(
    logic [31:0] tx, int len, int mm);
    if (mm == 0) return tx & mask(len);
    if (mm == 1) return mask(len);
    return 32'd0;
  endfunction

  function automatic logic [31:0] cfg_word(
    bit cpha, bit cpol, bit lsb, int len, int cs);
    logic [2:0] c;
    logic [4:0] l;
    c = 3'(cs);
    l = 5'(len - 1);
    return {13'b0, c, 3'b0, l, 5'b0,
            lsb, cpol, cpha};
  endfunction

  function automatic frm_t mk_frm(
    bit cpha, bit cpol, bit lsb, int len,
    int cs, int div, logic [31:0] tx);
    frm_t f;
    f.cpha   = cpha;
    f.cpol   = cpol;
    f.lsb    = lsb;
    f.len    = len;
    f.sel    = (cs < 4) ? cs : 0;
    f.cycles = (2 * len + 2) * (div + 1);
    f.word   = tx & mask(len);
    return f;
  endfunction

  // Read monitor: data valid the cycle after re.
  logic rd_v = 1'b0;
  always @(posedge clk) rd_v <= re;

  always @(negedge clk) begin
    if (rd_v) begin
      if (rd_q.size() == 0) begin
        n_tot++;
        $display("FAIL rd_unexpected: none queued");
      end else begin
        chk(rdn_q.pop_front(), read_data,
            rd_q.pop_front());
      end
    end
  end

  // Frame monitor: rebuilds the wire word.
  bit          act = 1'b0;
  bit          trk = 1'b0;
  frm_t        cur;
  int          cyc, edges, nb;
  logic [31:0] word;
  logic        prev;
  bit          cs_ok;
  bit          lead;

  always @(negedge clk) begin
    if (busy === 1'b1 && !act) begin
      act   = 1'b1;
      trk   = frm_q.size() > 0;
      cyc   = 0;
      edges = 0;
      nb    = 0;
      word  = '0;
      cs_ok = 1'b1;
      prev  = sclk;
      if (trk) cur = frm_q[0];
      else begin
        n_tot++;
        $display("FAIL frame_unexpected: no entry");
      end
    end
    if (act && trk && busy === 1'b1) begin
      cyc++;
      if (sclk !== prev) begin
        edges++;
        lead = (prev == cur.cpol);
        if (lead != cur.cpha) begin
          if (cur.lsb) begin
            if (nb < 32) word[nb] = mosi;
          end else begin
            word = {word[30:0], mosi};
          end
          nb++;
        end
        prev = sclk;
      end
      if (cs_n !== 4'(~(4'b0001 << cur.sel)))
        cs_ok = 1'b0;
    end
    if (act && busy === 1'b0) begin
      act = 1'b0;
      if (trk) begin
        cur = frm_q.pop_front();
        if (!abort_req) begin
          chk("busy_cycles", cyc, cur.cycles);
          chk("sclk_edges", edges, 2 * cur.len);
          chk("mosi_word", word, cur.word);
          chk("cs_sel", cs_ok, 1);
          chk("cs_done", cs_n, 4'hF);
          chk("sclk_idle", sclk, cur.cpol);
        end
      end
    end
  end

  task automatic wr(logic [2:0] a, logic [31:0] d);
    addr = a;
    write_data = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] e,
                    string nm);
    addr = a;
    re = 1'b1;
    rd_q.push_back(e);
    rdn_q.push_back(nm);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic launch(bit cpha, bit cpol, bit lsb,
                        int len, int cs, int div,
                        logic [31:0] tx, int mm);
    miso_mode = mm;
    wr(A_DIV, 32'(div));
    wr(A_CFG, cfg_word(cpha, cpol, lsb, len, cs));
    wr(A_TX, tx);
    frm_q.push_back(mk_frm(cpha, cpol, lsb,
                           len, cs, div, tx));
    wr(A_CTRL, {30'b0, irq_en, 1'b1});
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b1) begin
      n_tot++;
      $display("FAIL busy_rise: timeout");
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) begin
      n_tot++;
      $display("FAIL busy_fall: timeout");
    end
  endtask

  task automatic frame(bit cpha, bit cpol, bit lsb,
                       int len, int cs, int div,
                       logic [31:0] tx, int mm);
    launch(cpha, cpol, lsb, len, cs, div, tx, mm);
    wait_frame();
    rd(A_STAT, 32'd2, "status_done");
    rd(A_RX, exp_rx(tx, len, mm), "rxdata");
    rd(A_STAT, 32'd0, "status_clr");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_read_data", read_data, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    @(negedge clk);
    rd(A_CTRL, 0, "rst_ctrl");
    rd(A_CFG, 0, "rst_cfg");
    rd(A_DIV, 0, "rst_div");
    rd(A_TX, 0, "rst_tx");
    rd(A_RX, 0, "rst_rx");
    rd(A_STAT, 0, "rst_stat");

    frame(0, 0, 0, 8, 0, 1, 32'hA5, 0);
    frame(1, 1, 1, 24, 2, 2, 32'h123456, 0);
    chk("sclk_idle_hi", sclk, 1);
    frame(0, 0, 0, 32, 0, 0, 32'h789ABCDE, 1);

    launch(0, 1, 0, 16, 1, 2, 32'hC3C35A5A, 0);
    wr(A_TX, 32'd0);
    wr(A_CTRL, 32'd1);
    wr(A_CFG, cfg_word(1, 0, 1, 9, 3));
    wr(A_DIV, 32'd0);
    wait_frame();
    rd(A_RX, 32'h00005A5A, "busy_rx");
    rd(A_TX, 32'hC3C35A5A, "busy_tx");
    rd(A_DIV, 32'd2, "busy_div");
    rd(A_CFG, cfg_word(0, 1, 0, 16, 1), "busy_cfg");
    repeat (4) @(negedge clk);
    chk("no_restart", busy, 0);

    irq_en = 1'b1;
    launch(1, 0, 0, 12, 3, 1, 32'h0ABC, 0);
    chk("irq_busy", irq, 0);
    wait_frame();
    chk("irq_done", irq, 1);
    rd(A_STAT, 32'd2, "irq_stat");
    rd(A_RX, 32'h0ABC, "irq_rx");
    chk("irq_rx_clr", irq, 0);
    launch(0, 0, 1, 8, 0, 0, 32'h5C, 2);
    wait_frame();
    chk("irq_done2", irq, 1);
    wr(A_STAT, 32'd2);
    chk("irq_stat_clr", irq, 0);
    rd(A_STAT, 32'd0, "stat_wclr");
    irq_en = 1'b0;

    launch(0, 0, 0, 10, 1, 1, 32'h2D3, 0);
    wait_frame();
    frm_q.push_back(mk_frm(0, 0, 0, 10, 1, 1,
                           32'h2D3));
    wr(A_CTRL, 32'd1);
    wait_frame();
    rd(A_RX, 32'h2D3, "done_restart_rx");

    rd(A_TX, 32'h2D3, "hold_src");
    repeat (3) @(negedge clk);
    chk("rd_hold", read_data, 32'h2D3);
    rd(3'd6, 0, "unmapped6");
    rd(3'd7, 0, "unmapped7");

    for (int i = 0; i < 20; i++) begin
      bit          a, b, c;
      int          ln, cs, dv, mm;
      logic [31:0] tx;
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      ln = int'($urandom_range(8, 32));
      cs = int'($urandom_range(0, 7));
      dv = int'($urandom_range(0, 3));
      mm = int'($urandom_range(0, 2));
      tx = $urandom;
      frame(a, b, c, ln, cs, dv, tx, mm);
    end

    irq_en = 1'b1;
    launch(0, 1, 0, 16, 3, 3, 32'hBEEF, 0);
    repeat (30) @(negedge clk);
    abort_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 4'hF);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_irq", irq, 0);
    rst = 1'b0;
    irq_en = 1'b0;
    rd(A_STAT, 0, "abort_stat");
    abort_req = 1'b0;
    frame(0, 0, 0, 8, 0, 0, 32'h3C, 0);

    repeat (3) @(negedge clk);
    chk("frm_q_empty", frm_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
